hamming_secded_pipe: RTL and testbench

Parametrised, pipelined Hamming SECDED codec: the successor to the fixed 4-bit Hamming encoder. It encodes DATA_W-bit data into an extended Hamming word, or decodes a received word: it corrects single errors, flags double errors, and keeps saturating error counters. It sits between the switch/LED front end and any channel or fault-injection logic. Transfers use valid/ready handshakes on both sides.

---
 rtl/hamming_pkg.sv | 35 +++
 rtl/hamming_nucleo.sv | 56 +++++
 rtl/hamming_secded_pipe.sv | 138 +++++++++++++
 tb/tb_hamming_secded_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants, position helpers and mode type for the SECDED codec
package hamming_pkg;

  typedef enum logic {
    MODO_COD = 1'b0,
    MODO_DEC = 1'b1
  } modo_t;

  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic bit es_pot2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order, starting at 3.
  function automatic int data_pos(input int idx);
    int pos;
    int cuenta;
    pos = 0;
    cuenta = 0;
    for (int p = 3; p < 128; p++) begin
      if (!es_pot2(p)) begin
        if (cuenta == idx && pos == 0) pos = p;
        cuenta++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_nucleo.sv
// rtl/hamming_nucleo.sv - combinational Hamming core: encoded word, syndrome, global parity, raw data
module hamming_nucleo
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic [DATA_W-1:0] dato,
  input  logic [CODE_W-1:0] palabra,
  output logic [CODE_W-1:0] codificada,
  output logic [PAR_W-1:0]  sindrome,
  output logic              paridad,
  output logic [DATA_W-1:0] datos
);

  // Positions 1..CODE_W-1 whose index has bit k set.
  function automatic logic [CODE_W-1:0] mascara(input int k);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (((p >> k) & 1) == 1) m = m | (CODE_W'(1) << p);
    end
    return m;
  endfunction

  logic [CODE_W-1:0] w_datos;
  logic [CODE_W-1:0] w_par;
  logic [CODE_W-1:0] w_sin;

  generate
    for (genvar i = 0; i < DATA_W; i++) begin : g_dat
      localparam int P = data_pos(i);
      assign w_datos[P] = dato[i];
      assign datos[i]   = palabra[P];
    end
    for (genvar p = 0; p < CODE_W; p++) begin : g_pos
      if (p == 0 || es_pot2(p)) begin : g_hueco
        assign w_datos[p] = 1'b0;
      end
      if (p > 0 && es_pot2(p)) begin : g_par
        assign w_par[p] = ^(w_datos & mascara($clog2(p)));
      end else begin : g_nopar
        assign w_par[p] = 1'b0;
      end
    end
    for (genvar k = 0; k < PAR_W; k++) begin : g_sin
      assign sindrome[k] = ^(palabra & mascara(k));
    end
  endgenerate

  assign w_sin      = w_datos | w_par;
  assign codificada = {w_sin[CODE_W-1:1], ^w_sin[CODE_W-1:1]};
  assign paridad    = ^palabra;

endmodule

// File: rtl/hamming_secded_pipe.sv
// rtl/hamming_secded_pipe.sv - two-stage SECDED encode/decode pipeline with handshakes and error counters
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W = 16,
  localparam int PAR_W = calc_par_w(DATA_W),
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              modo,
  input  logic [CODE_W-1:0] entrada,
  input  logic              entrada_valida,
  output logic              entrada_lista,
  output logic [CODE_W-1:0] salida_palabra,
  output logic [DATA_W-1:0] salida_datos,
  output logic [PAR_W-1:0]  sindrome,
  output logic              error_simple,
  output logic              error_doble,
  output logic              salida_valida,
  input  logic              salida_lista,
  input  logic              borrar_cnt,
  output logic [CNT_W-1:0]  cnt_simples,
  output logic [CNT_W-1:0]  cnt_dobles
);

  localparam logic [PAR_W:0]   SIN_LIM = (PAR_W + 1)'(CODE_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CODE_W-1:0] nuc_cod;
  logic [PAR_W-1:0]  nuc_sin;
  logic              nuc_par;
  logic [DATA_W-1:0] nuc_datos;

  hamming_nucleo #(.DATA_W(DATA_W)) u_nucleo (
    .dato       (entrada[DATA_W-1:0]),
    .palabra    (entrada),
    .codificada (nuc_cod),
    .sindrome   (nuc_sin),
    .paridad    (nuc_par),
    .datos      (nuc_datos)
  );

  logic              s1_valid;
  modo_t             s1_modo;
  logic [CODE_W-1:0] s1_palabra;
  logic [DATA_W-1:0] s1_datos;
  logic [PAR_W-1:0]  s1_sin;
  logic              s1_par;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv        = !salida_valida || salida_lista;
  assign s1_adv        = !s1_valid || s2_adv;
  assign entrada_lista = s1_adv;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_modo    <= MODO_COD;
      s1_palabra <= '0;
      s1_datos   <= '0;
      s1_sin     <= '0;
      s1_par     <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= entrada_valida;
      if (entrada_valida) begin
        s1_modo    <= modo_t'(modo);
        s1_palabra <= modo ? entrada : nuc_cod;
        s1_datos   <= modo ? nuc_datos : entrada[DATA_W-1:0];
        s1_sin     <= modo ? nuc_sin : '0;
        s1_par     <= modo & nuc_par;
      end
    end
  end

  // A syndrome pointing past the word cannot be a single error, whatever the parity says.
  logic              es_dec;
  logic              fuera;
  logic              corr_simple;
  logic              corr_doble;
  logic [CODE_W-1:0] volteo;
  logic [DATA_W-1:0] datos_corr;

  assign es_dec      = (s1_modo == MODO_DEC);
  assign fuera       = {1'b0, s1_sin} >= SIN_LIM;
  assign corr_simple = es_dec && s1_par && !fuera;
  assign corr_doble  = es_dec && (((s1_sin != '0) && !s1_par) || fuera);

  generate
    for (genvar p = 0; p < CODE_W; p++) begin : g_volteo
      assign volteo[p] = corr_simple && (s1_sin == PAR_W'(p));
    end
    for (genvar i = 0; i < DATA_W; i++) begin : g_corr
      assign datos_corr[i] = s1_datos[i] ^ volteo[data_pos(i)];
    end
  endgenerate

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      salida_valida  <= 1'b0;
      salida_palabra <= '0;
      salida_datos   <= '0;
      sindrome       <= '0;
      error_simple   <= 1'b0;
      error_doble    <= 1'b0;
    end else if (s2_adv) begin
      salida_valida <= s1_valid;
      if (s1_valid) begin
        salida_palabra <= s1_palabra ^ volteo;
        salida_datos   <= datos_corr;
        sindrome       <= s1_sin;
        error_simple   <= corr_simple;
        error_doble    <= corr_doble;
      end
    end
  end

  logic entrega;
  assign entrega = salida_valida && salida_lista;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      cnt_simples <= '0;
      cnt_dobles  <= '0;
    end else if (borrar_cnt) begin
      cnt_simples <= '0;
      cnt_dobles  <= '0;
    end else begin
      if (entrega && error_simple && cnt_simples != CNT_MAX) cnt_simples <= cnt_simples + 1'b1;
      if (entrega && error_doble && cnt_dobles != CNT_MAX) cnt_dobles <= cnt_dobles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb/tb_hamming_secded_pipe.sv - scoreboard bench for the SECDED pipeline (DATA_W=4, CNT_W=4)
module tb_hamming_secded_pipe;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  logic       reloj;
  logic       reset;
  logic       modo;
  logic [7:0] entrada;
  logic       entrada_valida;
  logic       entrada_lista;
  logic [7:0] salida_palabra;
  logic [3:0] salida_datos;
  logic [2:0] sindrome;
  logic       error_simple;
  logic       error_doble;
  logic       salida_valida;
  logic       salida_lista;
  logic       borrar_cnt;
  logic [3:0] cnt_simples;
  logic [3:0] cnt_dobles;

  hamming_secded_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .reloj          (reloj),
    .reset          (reset),
    .modo           (modo),
    .entrada        (entrada),
    .entrada_valida (entrada_valida),
    .entrada_lista  (entrada_lista),
    .salida_palabra (salida_palabra),
    .salida_datos   (salida_datos),
    .sindrome       (sindrome),
    .error_simple   (error_simple),
    .error_doble    (error_doble),
    .salida_valida  (salida_valida),
    .salida_lista   (salida_lista),
    .borrar_cnt     (borrar_cnt),
    .cnt_simples    (cnt_simples),
    .cnt_dobles     (cnt_dobles)
  );

  typedef struct packed {
    logic [7:0] word;
    logic [3:0] data;
    logic [2:0] sind;
    logic       es;
    logic       ed;
  } exp_t;

  typedef struct {
    logic       modo;
    logic [7:0] entrada;
    exp_t       exp;
  } vec_t;

  exp_t q[$];
  exp_t exp_pend;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] m_cs;
  logic [3:0] m_cd;
  logic       hold;
  logic [7:0] prev_word;
  logic [3:0] prev_data;
  logic [2:0] prev_sind;
  logic       prev_es;
  logic       prev_ed;

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nombre, act, req);
    end
  endtask

  // Reference codec for the 8-bit word: data at 3,5,6,7; parity at 1,2,4; global parity at 0.
  function automatic exp_t model(input logic m, input logic [7:0] e);
    exp_t       r;
    logic [7:0] w;
    logic [2:0] s;
    logic       p;
    r = '0;
    if (!m) begin
      w = '0;
      w[3] = e[0];
      w[5] = e[1];
      w[6] = e[2];
      w[7] = e[3];
      for (int k = 0; k < 3; k++) begin
        p = 1'b0;
        for (int i = 1; i < 8; i++) begin
          if (((i >> k) & 1) == 1) p = p ^ (((w >> i) & 8'd1) != 8'd0);
        end
        if (p) w = w | (8'd1 << (1 << k));
      end
      w[0] = ^w[7:1];
      r.word = w;
      r.data = e[3:0];
    end else begin
      s = '0;
      for (int i = 1; i < 8; i++) begin
        if (((e >> i) & 8'd1) != 8'd0) s = s ^ 3'(i);
      end
      p = ^e;
      w = e;
      if (p) begin
        w = w ^ (8'd1 << s);
        r.es = 1'b1;
      end else if (s != 3'd0) begin
        r.ed = 1'b1;
      end
      r.word = w;
      r.data = {w[7], w[6], w[5], w[3]};
      r.sind = s;
    end
    return r;
  endfunction

  always @(negedge reloj) begin
    exp_t e;
    if (reset) begin
      q.delete();
      m_cs = '0;
      m_cd = '0;
      hold = 1'b0;
      chk("rst_salida_valida", 32'(salida_valida), 32'd0);
      chk("rst_cnt_simples", 32'(cnt_simples), 32'd0);
      chk("rst_cnt_dobles", 32'(cnt_dobles), 32'd0);
    end else begin
      chk("cnt_simples", 32'(cnt_simples), 32'(m_cs));
      chk("cnt_dobles", 32'(cnt_dobles), 32'(m_cd));
      chk("entrada_lista", 32'(entrada_lista), 32'(!(q.size() == 2 && !salida_lista)));
      if (hold) begin
        chk("hold_valid", 32'(salida_valida), 32'd1);
        chk("hold_word", 32'(salida_palabra), 32'(prev_word));
        chk("hold_data", 32'(salida_datos), 32'(prev_data));
        chk("hold_flags", 32'({sindrome, error_simple, error_doble}), 32'({prev_sind, prev_es, prev_ed}));
      end
      if (salida_valida && salida_lista) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(q.size()), 32'd1);
          e = '0;
        end else begin
          e = q.pop_front();
          chk("word", 32'(salida_palabra), 32'(e.word));
          chk("data", 32'(salida_datos), 32'(e.data));
          chk("sindrome", 32'(sindrome), 32'(e.sind));
          chk("error_simple", 32'(error_simple), 32'(e.es));
          chk("error_doble", 32'(error_doble), 32'(e.ed));
        end
        if (!borrar_cnt) begin
          if (e.es && m_cs != 4'hF) m_cs = m_cs + 4'd1;
          if (e.ed && m_cd != 4'hF) m_cd = m_cd + 4'd1;
        end
      end
      if (borrar_cnt) begin
        m_cs = '0;
        m_cd = '0;
      end
      hold      = salida_valida && !salida_lista;
      prev_word = salida_palabra;
      prev_data = salida_datos;
      prev_sind = sindrome;
      prev_es   = error_simple;
      prev_ed   = error_doble;
      if (entrada_valida && entrada_lista) q.push_back(exp_pend);
    end
  end

  task automatic send(input logic m, input logic [7:0] e, input exp_t x);
    logic acc;
    acc = 1'b0;
    modo = m;
    entrada = e;
    exp_pend = x;
    entrada_valida = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge reloj);
      acc = entrada_lista;
      @(posedge reloj);
      #1;
    end
    if (!acc) chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && q.size() != 0; t++) @(posedge reloj);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic lat_test(input logic [7:0] v);
    send(1'b0, v, model(1'b0, v));
    entrada_valida = 1'b0;
    @(negedge reloj);
    chk("lat_1cyc", 32'(salida_valida), 32'd0);
    @(negedge reloj);
    chk("lat_2cyc", 32'(salida_valida), 32'd1);
    @(posedge reloj);
    #1;
    drain();
  endtask

  vec_t       vecs[11];
  logic [3:0] d;
  logic       m;
  logic [7:0] e;
  logic [7:0] f;

  initial begin
    vecs[0]  = '{1'b0, 8'h0B, '{8'hAA, 4'hB, 3'd0, 1'b0, 1'b0}};
    vecs[1]  = '{1'b1, 8'hAA, '{8'hAA, 4'hB, 3'd0, 1'b0, 1'b0}};
    vecs[2]  = '{1'b1, 8'h8A, '{8'hAA, 4'hB, 3'd5, 1'b1, 1'b0}};
    vecs[3]  = '{1'b1, 8'hAB, '{8'hAA, 4'hB, 3'd0, 1'b1, 1'b0}};
    vecs[4]  = '{1'b1, 8'h82, '{8'h82, 4'h8, 3'd6, 1'b0, 1'b1}};
    vecs[5]  = '{1'b0, 8'h05, '{8'h5A, 4'h5, 3'd0, 1'b0, 1'b0}};
    vecs[6]  = '{1'b0, 8'h0F, '{8'hFF, 4'hF, 3'd0, 1'b0, 1'b0}};
    vecs[7]  = '{1'b1, 8'hF7, '{8'hFF, 4'hF, 3'd3, 1'b1, 1'b0}};
    vecs[8]  = '{1'b1, 8'hDA, '{8'h5A, 4'h5, 3'd7, 1'b1, 1'b0}};
    vecs[9]  = '{1'b1, 8'h59, '{8'h59, 4'h5, 3'd1, 1'b0, 1'b1}};
    vecs[10] = '{1'b0, 8'hF5, '{8'h5A, 4'h5, 3'd0, 1'b0, 1'b0}};

    reset = 1'b1;
    modo = 1'b0;
    entrada = '0;
    entrada_valida = 1'b0;
    salida_lista = 1'b1;
    borrar_cnt = 1'b0;
    exp_pend = '0;
    repeat (2) @(posedge reloj);
    @(negedge reloj);
    chk("rst_entrada_lista", 32'(entrada_lista), 32'd1);
    chk("rst_palabra", 32'(salida_palabra), 32'd0);
    chk("rst_datos", 32'(salida_datos), 32'd0);
    chk("rst_flags", 32'({sindrome, error_simple, error_doble}), 32'd0);
    @(posedge reloj);
    #1;
    reset = 1'b0;

    lat_test(8'h0B);

    for (int i = 0; i < 11; i++) send(vecs[i].modo, vecs[i].entrada, vecs[i].exp);
    entrada_valida = 1'b0;
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = 4'($urandom_range(0, 15));
          m = 1'($urandom_range(0, 1));
          f = '0;
          for (int j = 0; j < i % 3; j++) f = f | (8'd1 << $urandom_range(0, 7));
          e = m ? (model(1'b0, {4'h0, d}).word ^ f) : {4'($urandom_range(0, 15)), d};
          send(m, e, model(m, e));
        end
        entrada_valida = 1'b0;
      end
      begin
        repeat (4) @(posedge reloj);
        #1;
        salida_lista = 1'b0;
        repeat (3) @(posedge reloj);
        #1;
        salida_lista = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 20; i++) send(1'b1, 8'h8A, model(1'b1, 8'h8A));
    entrada_valida = 1'b0;
    drain();
    @(negedge reloj);
    chk("sat_cnt_simples", 32'(cnt_simples), 32'hF);
    @(posedge reloj);
    #1;

    send(1'b1, 8'h8A, model(1'b1, 8'h8A));
    entrada_valida = 1'b0;
    @(posedge reloj);
    #1;
    borrar_cnt = 1'b1;
    @(posedge reloj);
    #1;
    borrar_cnt = 1'b0;
    @(negedge reloj);
    chk("clr_wins", 32'(cnt_simples), 32'd0);
    @(posedge reloj);
    #1;

    send(1'b1, 8'h82, model(1'b1, 8'h82));
    send(1'b1, 8'h8A, model(1'b1, 8'h8A));
    entrada_valida = 1'b0;
    reset = 1'b1;
    @(negedge reloj);
    chk("midrst_valid", 32'(salida_valida), 32'd0);
    chk("midrst_cnt_dobles", 32'(cnt_dobles), 32'd0);
    chk("midrst_cnt_simples", 32'(cnt_simples), 32'd0);
    @(posedge reloj);
    #1;
    reset = 1'b0;
    lat_test(8'h0B);

    repeat (4) @(posedge reloj);
    #1;
    chk("final_queue", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
